// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over a READ/BUSYWAIT handshake into a small prefetch FIFO.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds MISALIGN_FAULT and the S_HALT trap.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_FETCH    | normal prefetch; pushes completed words into the FIFO
// S_DISCARD  | wrong-path request still outstanding; address held, data dropped
// S_HALT     | misaligned redirect seen; fetch stopped until RESET
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        VALID_OUT,
    output logic [31:0] INSTR_OUT,
    output logic [31:0] PC_OUT,
    output logic [24:0] IMM_FIELD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        MISALIGN_FAULT
`endif
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        target_q;
    logic               halt_pend;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pc_mem  [FIFO_DEPTH];
    logic [31:0]        ins_mem [FIFO_DEPTH];

    logic               misalign;
    logic [31:0]        target_eff;
    logic               pop;
    logic               do_pop;
    logic               push;
    logic               flush;
    logic               done;
    logic               outstanding;
    logic               unused_tgt_lsb;

    // Low target bits never reach the PC; they only feed the misalign check.
    assign target_eff     = {BRANCH_TARGET[31:2], 2'b00};
    assign unused_tgt_lsb = ^BRANCH_TARGET[1:0];
`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    assign misalign       = BRANCH_TARGET[1:0] != 2'b00;
    assign MISALIGN_FAULT = fault_q;
`else
    assign misalign       = 1'b0;
`endif

    assign VALID_OUT = count != '0;
    assign INSTR_OUT = VALID_OUT ? ins_mem[rd_ptr] : NOP;
    assign PC_OUT    = VALID_OUT ? pc_mem[rd_ptr]  : 32'h0;
    assign IMM_FIELD = INSTR_OUT[31:7];

    assign pop = VALID_OUT && !STALL;

    always_comb begin
        IMEM_READ = 1'b0;
        if (!RESET) begin
            case (state)
                S_FETCH:   IMEM_READ = (count != DEPTH_C) || pop;
                S_DISCARD: IMEM_READ = 1'b1;
                default:   IMEM_READ = 1'b0;
            endcase
        end
    end

    assign IMEM_ADDR   = fetch_pc;
    assign done        = IMEM_READ && !IMEM_BUSYWAIT;
    assign outstanding = IMEM_READ && IMEM_BUSYWAIT;
    assign flush       = BRANCH_TAKEN && (state != S_HALT);
    assign push        = done && (state == S_FETCH) && !BRANCH_TAKEN;
    assign do_pop      = pop && !flush;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            target_q  <= RESET_PC;
            halt_pend <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]  <= fetch_pc;
                    ins_mem[wr_ptr] <= IMEM_READDATA;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

`ifdef FETCH_MISALIGN_CHECK_EN
            if (flush && misalign)
                fault_q <= 1'b1;
`endif

            case (state)
                S_FETCH: begin
                    if (BRANCH_TAKEN) begin
                        if (outstanding) begin
                            // Old address must stay on the bus until memory answers.
                            state     <= S_DISCARD;
                            target_q  <= target_eff;
                            halt_pend <= misalign;
                        end else if (misalign) begin
                            state <= S_HALT;
                        end else begin
                            fetch_pc <= target_eff;
                        end
                    end else if (push) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                S_DISCARD: begin
                    if (BRANCH_TAKEN) begin
                        target_q  <= target_eff;
                        halt_pend <= halt_pend || misalign;
                    end
                    if (done) begin
                        if (halt_pend || (BRANCH_TAKEN && misalign))
                            state <= S_HALT;
                        else begin
                            state    <= S_FETCH;
                            fetch_pc <= BRANCH_TAKEN ? target_eff : target_q;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: program-order stream expected at each pop,
// plus directed timing checks on the fetch handshake.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic        VALID_OUT;
    logic [31:0] INSTR_OUT;
    logic [31:0] PC_OUT;
    logic [24:0] IMM_FIELD;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        MISALIGN_FAULT;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .STALL         (STALL),
        .VALID_OUT     (VALID_OUT),
        .INSTR_OUT     (INSTR_OUT),
        .PC_OUT        (PC_OUT),
`ifdef FETCH_MISALIGN_CHECK_EN
        .MISALIGN_FAULT(MISALIGN_FAULT),
`endif
        .IMM_FIELD     (IMM_FIELD)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0003;
    endfunction

    // Address-tagged instruction memory.
    assign IMEM_READDATA = mem_word(IMEM_ADDR);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        sb_q.delete();
        p = pc;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back({p, mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!VALID_OUT && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("wait_valid", 32'(VALID_OUT), 32'd1);
    endtask

    // Every entry the DUT hands downstream must be the next one in program order.
    always @(negedge CLK) begin
        logic [63:0] e;
        logic [31:0] ei;
        if (!RESET && VALID_OUT && !STALL && !BRANCH_TAKEN) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                ei = e[31:0];
                check_eq("pop_pc", PC_OUT, e[63:32]);
                check_eq("pop_instr", INSTR_OUT, ei);
                check_eq("pop_imm", {7'b0, IMM_FIELD}, {7'b0, ei[31:7]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = 32'h0; STALL = 1'b0;
        sb_q.delete();
        tick(); tick();
        check_eq("rst_read", 32'(IMEM_READ), 32'd0);
        check_eq("rst_addr", IMEM_ADDR, 32'h0);
        check_eq("rst_valid", 32'(VALID_OUT), 32'd0);
        check_eq("rst_instr", INSTR_OUT, 32'h0000_0013);
        check_eq("rst_pc", PC_OUT, 32'h0);

        // Zero-wait streaming from reset.
        RESET = 1'b0;
        sb_restart(32'h0);
        #1;
        check_eq("c0_read", 32'(IMEM_READ), 32'd1);
        check_eq("c0_addr", IMEM_ADDR, 32'h0);
        check_eq("c0_valid", 32'(VALID_OUT), 32'd0);
        tick();
        w0 = mem_word(32'h0);
        check_eq("c1_addr", IMEM_ADDR, 32'h4);
        check_eq("c1_valid", 32'(VALID_OUT), 32'd1);
        check_eq("c1_pc", PC_OUT, 32'h0);
        check_eq("c1_instr", INSTR_OUT, w0);
        check_eq("c1_imm", {7'b0, IMM_FIELD}, {7'b0, w0[31:7]});
        tick();
        check_eq("c2_addr", IMEM_ADDR, 32'h8);
        tick();
        check_eq("c3_addr", IMEM_ADDR, 32'hC);

        // Stall: FIFO fills and the read request drops.
        STALL = 1'b1;
        tick();
        check_eq("full_read", 32'(IMEM_READ), 32'd0);
        check_eq("full_pc", PC_OUT, 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stall_read", 32'(IMEM_READ), 32'd0);
            check_eq("stall_addr", IMEM_ADDR, 32'h10);
        end

        // Release stall into a busy memory on 0x10, then redirect while it is outstanding.
        STALL = 1'b0; IMEM_BUSYWAIT = 1'b1;
        #1;
        check_eq("rel_read", 32'(IMEM_READ), 32'd1);
        check_eq("rel_addr", IMEM_ADDR, 32'h10);
        tick();
        check_eq("busy_a_pc", PC_OUT, 32'hC);
        check_eq("busy_a_addr", IMEM_ADDR, 32'h10);
        tick();
        check_eq("busy_b_valid", 32'(VALID_OUT), 32'd0);
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
        sb_restart(32'h100);
        tick();
        BRANCH_TAKEN = 1'b0;
        check_eq("disc_read", 32'(IMEM_READ), 32'd1);
        check_eq("disc_addr", IMEM_ADDR, 32'h10);
        check_eq("disc_valid", 32'(VALID_OUT), 32'd0);
        tick();
        check_eq("disc_addr2", IMEM_ADDR, 32'h10);
        IMEM_BUSYWAIT = 1'b0;
        tick();
        check_eq("redir_addr", IMEM_ADDR, 32'h100);
        check_eq("redir_valid", 32'(VALID_OUT), 32'd0);
        wait_valid(4);
        check_eq("redir_pc", PC_OUT, 32'h100);
        tick(); tick(); tick();

        // Redirect on an edge with a simultaneous pop and completing push.
        check_eq("pre40_valid", 32'(VALID_OUT), 32'd1);
        check_eq("pre40_read", 32'(IMEM_READ), 32'd1);
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
        sb_restart(32'h40);
        tick();
        BRANCH_TAKEN = 1'b0;
        check_eq("b40_valid", 32'(VALID_OUT), 32'd0);
        check_eq("b40_addr", IMEM_ADDR, 32'h40);
        check_eq("b40_read", 32'(IMEM_READ), 32'd1);
        tick();
        check_eq("b40_pc", PC_OUT, 32'h40);
        tick(); tick(); tick();

        // PC wrap-around.
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
        sb_restart(32'hFFFF_FFFC);
        tick();
        BRANCH_TAKEN = 1'b0;
        check_eq("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr1", IMEM_ADDR, 32'h0);
        check_eq("wrap_pc", PC_OUT, 32'hFFFF_FFFC);
        tick(); tick();

        // Reset in the middle of a stalled request.
        IMEM_BUSYWAIT = 1'b1;
        tick();
        RESET = 1'b1;
        sb_q.delete();
        tick();
        check_eq("mrst_read", 32'(IMEM_READ), 32'd0);
        check_eq("mrst_addr", IMEM_ADDR, 32'h0);
        check_eq("mrst_valid", 32'(VALID_OUT), 32'd0);
        check_eq("mrst_instr", INSTR_OUT, 32'h0000_0013);
        check_eq("mrst_pc", PC_OUT, 32'h0);
        tick();
        RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
        sb_restart(32'h0);
        wait_valid(4);
        check_eq("mrst_first_pc", PC_OUT, 32'h0);
        tick(); tick(); tick();

        // Misaligned redirect.
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
        sb_q.delete();
        tick();
        BRANCH_TAKEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("halt_fault", 32'(MISALIGN_FAULT), 32'd1);
            check_eq("halt_read", 32'(IMEM_READ), 32'd0);
            check_eq("halt_valid", 32'(VALID_OUT), 32'd0);
            tick();
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_eq("halt_clr", 32'(MISALIGN_FAULT), 32'd0);
`else
        sb_restart(32'h100);
        tick();
        BRANCH_TAKEN = 1'b0;
        check_eq("mis_addr", IMEM_ADDR, 32'h100);
        tick();
        check_eq("mis_pc", PC_OUT, 32'h100);
        tick(); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
